en_strobe_gen: RTL
==================

# en_strobe_gen

Programmable clock-enable strobe generator. It produces single-cycle `en` pulses at a programmable spacing, either continuously or as a counted burst. Its `en` output directly drives the enable inputs of the team's enabled D flip-flops and registers, so slow-rate logic runs on the main clock without gated clocks. A start/stop/busy/done handshake lets a controlling FSM launch and track bursts.

## Interface
- `CNT_W`, 16: width of the period input and the internal divider counter.
- `BURST_W`, 8: width of the burst length and the strobe counter.

- `clk`  in  1  the only clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1  launch request; honoured only in IDLE.
- `stop`  in  1  abort request; honoured only in RUN.
- `mode`  in  1  0 = continuous, 1 = burst; sampled when `start` is accepted.
- `period`  in  CNT_W  strobe spacing in cycles; 0 and 1 both mean every cycle; sampled when `start` is accepted.
- `burst_len`  in  BURST_W  number of strobes in burst mode; sampled when `start` is accepted.
- `en`  out  1  registered single-cycle strobe.
- `busy`  out  1  registered; high while in RUN.
- `done`  out  1  registered one-cycle pulse when a burst completes.
- `strobe_cnt`  out  BURST_W  registered count of strobes issued since the last accepted `start`.

## Operation
- FSM has two states: IDLE and RUN.
- Shadow registers:
  - On an accepted `start`, capture `mode` and `burst_len`, and capture `period` as `period_q = max(period, 1)`.
  - Input changes during RUN have no effect.
- IDLE:
  - `start=1` and `stop=0` → go to RUN and clear `strobe_cnt`.
  - Exception: if `mode=1` and `burst_len=0`, stay in IDLE, issue no `en`, pulse `done`, and clear `strobe_cnt`.
- RUN:
  - An internal divider issues `en` every `period_q` cycles.
  - The first strobe comes immediately after `start` is accepted.
  - Each strobe increments `strobe_cnt`. In continuous mode, `strobe_cnt` saturates at all-ones.
  - Burst mode: after the strobe that brings `strobe_cnt` to `burst_len`, go to IDLE and pulse `done`.
  - `stop=1` → go to IDLE with no `done`. `strobe_cnt` holds its value. The divider is cleared.
  - `start` is ignored in RUN.
- Simultaneous events:
  - `start` and `stop` together in IDLE: `stop` wins; remain in IDLE.
  - `stop` sampled on the edge that would issue a strobe: `stop` wins; no `en`.
- `strobe_cnt` holds its value in IDLE until the next accepted `start`.

## Timing
- Reset: `rst_n=0` on an edge puts every output to 0 on the next cycle: `en`, `busy`, `done`, `strobe_cnt`.
  - FSM goes to IDLE; the divider and shadow registers are cleared.
  - Applies even mid-burst. Reset has priority over `start` and `stop`.
- `start` accepted at edge k:
  - `busy=1` and `en=1` in cycle k+1.
  - Further strobes in cycles k+1+n·`period_q`, n = 1, 2, …
  - `en` is never high for two consecutive cycles unless `period_q=1`.
- Burst end: last strobe in cycle m → `busy=0` and `done=1` in cycle m+1. `done` lasts exactly one cycle.
- Zero-length burst: `start` at edge k → `done=1` in cycle k+1; `busy` stays 0.
- `stop` sampled at edge j → `busy=0` and `en=0` from cycle j+1.
- `strobe_cnt` updates in the same cycle that `en` is high.
- Restart: a new `start` may be accepted on the same edge that `done` is registered. Back-to-back bursts therefore leave one idle cycle.

## Test plan
- Continuous mode, `period=3`, `start` at edge 0:
  - `en` high in cycles 1, 4, 7, 10; `busy=1` throughout.
  - `stop` at edge 11 → `busy=0` from cycle 12 and `strobe_cnt=4`.
- Burst mode, `period=2`, `burst_len=3`, `start` at edge 0:
  - `en` in cycles 1, 3, 5; `done` only in cycle 6; `busy` low from cycle 6.
  - `strobe_cnt=3` holds afterwards.
- Burst mode, `burst_len=0` → no `en`, `done` pulse in cycle 1, `busy` never high.
- `period` 0 and 1, continuous:
  - `en` high in every cycle from 1.
  - `stop` on a strobe edge suppresses that strobe.
- Mid-burst disturbances, `burst_len=5`:
  - Toggling `start`, `period` and `burst_len` during RUN leaves the schedule unchanged.
  - `rst_n=0` after the 2nd strobe → all outputs 0 next cycle, and no `done`.
- `start` and `stop` together in IDLE → stays IDLE, no `en`.
- Continuous run past 2^BURST_W strobes → `strobe_cnt` saturates at 255 with default `BURST_W`.

Source files
------------

// File: rtl/en_strobe_gen.sv
// Programmable clock-enable strobe generator: single-cycle en pulses every
// period_q cycles, continuous or as a counted burst, with start/stop/busy/done.
module en_strobe_gen #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [CNT_W-1:0]   period,
  input  logic [BURST_W-1:0] burst_len,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] strobe_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] BURST_ZERO = {BURST_W{1'b0}};
  localparam logic [BURST_W-1:0] BURST_ONE  = {{(BURST_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] BURST_MAX  = {BURST_W{1'b1}};

  logic [0:0]         r_state;
  logic               r_mode;
  logic [BURST_W-1:0] r_burst_len;
  logic [CNT_W-1:0]   r_period_q;
  logic [CNT_W-1:0]   r_div;
  logic               r_en;
  logic               r_busy;
  logic               r_done;
  logic [BURST_W-1:0] r_strobe_cnt;

  logic [0:0]         w_state_nxt;
  logic               w_load;
  logic               w_en_nxt;
  logic               w_done_nxt;
  logic [CNT_W-1:0]   w_div_nxt;
  logic [BURST_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0]   w_period_sat;
  logic               w_burst_end;
  logic               w_div_hit;

  // Periods 0 and 1 both collapse to a strobe every cycle.
  assign w_period_sat = (period < 16'(2)) ? CNT_ONE : period;
  assign w_burst_end  = r_mode && (r_strobe_cnt == r_burst_len);
  assign w_div_hit    = (r_div == (r_period_q - CNT_ONE));

  // Next-state, strobe, divider and counter decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_en_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_div_nxt   = r_div;
    w_cnt_nxt   = r_strobe_cnt;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          if (mode && (burst_len == BURST_ZERO)) begin
            w_done_nxt = 1'b1;
            w_cnt_nxt  = BURST_ZERO;
          end else begin
            // First strobe goes out immediately, so the count starts at one.
            w_load      = 1'b1;
            w_state_nxt = ST_RUN;
            w_en_nxt    = 1'b1;
            w_div_nxt   = CNT_ZERO;
            w_cnt_nxt   = BURST_ONE;
          end
        end else begin
          w_div_nxt = CNT_ZERO;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_div_nxt   = CNT_ZERO;
        end else if (w_burst_end) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_div_nxt   = CNT_ZERO;
        end else if (w_div_hit) begin
          w_en_nxt  = 1'b1;
          w_div_nxt = CNT_ZERO;
          if (r_strobe_cnt != BURST_MAX) begin
            w_cnt_nxt = r_strobe_cnt + BURST_ONE;
          end else begin
            w_cnt_nxt = r_strobe_cnt;
          end
        end else begin
          w_div_nxt = r_div + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_div_nxt   = CNT_ZERO;
      end
    endcase
  end

  // State, shadow and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_mode       <= 1'b0;
      r_burst_len  <= BURST_ZERO;
      r_period_q   <= CNT_ZERO;
      r_div        <= CNT_ZERO;
      r_en         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_strobe_cnt <= BURST_ZERO;
    end else begin
      r_state      <= w_state_nxt;
      r_div        <= w_div_nxt;
      r_en         <= w_en_nxt;
      r_busy       <= (w_state_nxt == ST_RUN);
      r_done       <= w_done_nxt;
      r_strobe_cnt <= w_cnt_nxt;
      if (w_load) begin
        r_mode      <= mode;
        r_burst_len <= burst_len;
        r_period_q  <= w_period_sat;
      end else begin
        r_mode      <= r_mode;
        r_burst_len <= r_burst_len;
        r_period_q  <= r_period_q;
      end
    end
  end

  assign en         = r_en;
  assign busy       = r_busy;
  assign done       = r_done;
  assign strobe_cnt = r_strobe_cnt;

endmodule
